// File: rtl/dmem_arbiter.sv
// Two-requester (CPU / DMA) arbiter for a single data-memory port with fixed read latency.
// Optional round-robin tie-breaking is built when DMEM_ARB_RR_EN is defined; otherwise the CPU wins ties.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              grant_dma_q, grant_dma_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dma_ack_q, dma_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              any_req_s;
  logic              pick_dma_s;

  assign any_req_s = cpu_req | dma_req;

`ifdef DMEM_ARB_RR_EN
  logic last_dma_q, last_dma_d;

  // Winner selection: on a tie the side that was not granted last goes next.
  always_comb begin
    if (cpu_req && dma_req) begin
      pick_dma_s = ~last_dma_q;
    end else begin
      pick_dma_s = dma_req;
    end
  end

  // Remember the side of every grant made from IDLE.
  always_comb begin
    if ((state_q == IDLE) && any_req_s) begin
      last_dma_d = pick_dma_s;
    end else begin
      last_dma_d = last_dma_q;
    end
  end

  // Last-grant register; resets to DMA so the CPU takes the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_dma_q <= 1'b1;
    end else begin
      last_dma_q <= last_dma_d;
    end
  end
`else
  // Winner selection: fixed priority, the CPU always wins a tie.
  always_comb begin
    if (cpu_req) begin
      pick_dma_s = 1'b0;
    end else begin
      pick_dma_s = dma_req;
    end
  end
`endif

  // Transaction FSM: next state, latched request and registered outputs.
  always_comb begin
    state_d     = state_q;
    grant_dma_d = grant_dma_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          grant_dma_d = pick_dma_s;
          mem_en_d    = 1'b1;
          mem_we_d    = pick_dma_s ? dma_we    : cpu_we;
          mem_addr_d  = pick_dma_s ? dma_addr  : cpu_addr;
          mem_wdata_d = pick_dma_s ? dma_wdata : cpu_wdata;
          state_d     = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        // mem_we_q still carries the latched direction during the strobe cycle
        if (mem_we_q) begin
          cpu_ack_d = ~grant_dma_q;
          dma_ack_d = grant_dma_q;
          state_d   = RESP;
        end else begin
          cnt_d   = 3'(RD_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd1) begin
          if (grant_dma_q) begin
            dma_rdata_d = mem_rdata;
          end else begin
            cpu_rdata_d = mem_rdata;
          end
          cpu_ack_d = ~grant_dma_q;
          dma_ack_d = grant_dma_q;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_dma_q <= 1'b0;
      cnt_q       <= 3'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= {DATA_W{1'b0}};
      dma_rdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      grant_dma_q <= grant_dma_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign cpu_stall = cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (RD_LAT=2) with a small memory model behind the port.
// The tie-break test follows DMEM_ARB_RR_EN.
module tb_dmem_arbiter;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'd0, cpu_wdata = 32'd0;
  logic [31:0] cpu_rdata;
  logic        cpu_ack, cpu_stall;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] dma_addr = 32'd0, dma_wdata = 32'd0;
  logic [31:0] dma_rdata;
  logic        dma_ack;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem_model [0:255];
  logic [31:0] rd_pipe [0:RD_LAT-1];

  int n_cmp = 0;
  int n_err = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory: writes land at the strobe edge, read data appears RD_LAT cycles after the strobe cycle.
  always @(posedge clk) begin
    if (mem_en && mem_we) mem_model[mem_addr[9:2]] <= mem_wdata;
    rd_pipe[0] <= (mem_en && !mem_we) ? mem_model[mem_addr[9:2]] : 32'hBAD0_BAD0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drv_cpu(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic drv_dma(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    dma_req = r; dma_we = w; dma_addr = a; dma_wdata = d;
  endtask

  initial begin
    // reset values
    step(); step();
    chk("rst_mem_en", mem_en, 32'd0);
    chk("rst_mem_we", mem_we, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_cpu_ack", cpu_ack, 32'd0);
    chk("rst_dma_ack", dma_ack, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_dma_rdata", dma_rdata, 32'd0);
    chk("rst_cpu_stall", cpu_stall, 32'd0);
    reset = 1'b0;
    step();

    // CPU write 0x10
    drv_cpu(1'b1, 1'b1, 32'h10, 32'hDEADBEEF); #1;
    chk("w1_stall_c0", cpu_stall, 32'd1);
    step();
    chk("w1_mem_en", mem_en, 32'd1);
    chk("w1_mem_we", mem_we, 32'd1);
    chk("w1_mem_addr", mem_addr, 32'h10);
    chk("w1_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("w1_ack_c1", cpu_ack, 32'd0);
    step();
    chk("w1_ack_c2", cpu_ack, 32'd1);
    chk("w1_en_c2", mem_en, 32'd0);
    chk("w1_stall_c2", cpu_stall, 32'd0);
    drv_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("w1_ack_c3", cpu_ack, 32'd0);

    // back-to-back CPU writes
    drv_cpu(1'b1, 1'b1, 32'h20, 32'hA5A5_0020);
    step();
    chk("b2b_en1", mem_en, 32'd1);
    chk("b2b_addr1", mem_addr, 32'h20);
    step();
    chk("b2b_ack1", cpu_ack, 32'd1);
    chk("b2b_en_c2", mem_en, 32'd0);
    drv_cpu(1'b1, 1'b1, 32'h24, 32'h5A5A_0024);
    step();
    chk("b2b_en_c3", mem_en, 32'd0);
    chk("b2b_ack_c3", cpu_ack, 32'd0);
    step();
    chk("b2b_en2", mem_en, 32'd1);
    chk("b2b_addr2", mem_addr, 32'h24);
    chk("b2b_wdata2", mem_wdata, 32'h5A5A_0024);
    step();
    chk("b2b_ack2", cpu_ack, 32'd1);
    drv_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // DMA write 0x40, CPU not stalled
    drv_dma(1'b1, 1'b1, 32'h40, 32'h12345678); #1;
    chk("dw_cpu_stall", cpu_stall, 32'd0);
    step();
    chk("dw_mem_en", mem_en, 32'd1);
    chk("dw_mem_addr", mem_addr, 32'h40);
    step();
    chk("dw_dma_ack", dma_ack, 32'd1);
    chk("dw_cpu_ack", cpu_ack, 32'd0);
    drv_dma(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // CPU read 0x40, RD_LAT=2 -> ack 4 cycles after request
    drv_cpu(1'b1, 1'b0, 32'h40, 32'h0); #1;
    chk("r_stall_c0", cpu_stall, 32'd1);
    step();
    chk("r_en_c1", mem_en, 32'd1);
    chk("r_we_c1", mem_we, 32'd0);
    chk("r_stall_c1", cpu_stall, 32'd1);
    step();
    chk("r_ack_c2", cpu_ack, 32'd0);
    chk("r_stall_c2", cpu_stall, 32'd1);
    step();
    chk("r_ack_c3", cpu_ack, 32'd0);
    chk("r_stall_c3", cpu_stall, 32'd1);
    step();
    chk("r_ack_c4", cpu_ack, 32'd1);
    chk("r_rdata_c4", cpu_rdata, 32'h12345678);
    chk("r_stall_c4", cpu_stall, 32'd0);
    drv_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("r_ack_c5", cpu_ack, 32'd0);
    chk("r_rdata_hold", cpu_rdata, 32'h12345678);
    chk("r_dma_rdata_untouched", dma_rdata, 32'd0);

    // DMA read 0x10 returns the first CPU write
    drv_dma(1'b1, 1'b0, 32'h10, 32'h0);
    step(); step(); step();
    chk("dr_ack_c3", dma_ack, 32'd0);
    step();
    chk("dr_ack_c4", dma_ack, 32'd1);
    chk("dr_rdata", dma_rdata, 32'hDEADBEEF);
    chk("dr_cpu_rdata_hold", cpu_rdata, 32'h12345678);
    drv_dma(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // tie: both requesters held
    drv_cpu(1'b1, 1'b1, 32'h80, 32'h11);
    drv_dma(1'b1, 1'b1, 32'h84, 32'h22);
`ifdef DMEM_ARB_RR_EN
    step();
    chk("rr_g1_addr", mem_addr, 32'h80);
    step();
    chk("rr_g1_cpu_ack", cpu_ack, 32'd1);
    chk("rr_g1_dma_ack", dma_ack, 32'd0);
    step(); step();
    chk("rr_g2_addr", mem_addr, 32'h84);
    chk("rr_g2_wdata", mem_wdata, 32'h22);
    step();
    chk("rr_g2_dma_ack", dma_ack, 32'd1);
    chk("rr_g2_cpu_ack", cpu_ack, 32'd0);
    step(); step();
    chk("rr_g3_addr", mem_addr, 32'h80);
    step();
    chk("rr_g3_cpu_ack", cpu_ack, 32'd1);
    chk("rr_g3_dma_ack", dma_ack, 32'd0);
    drv_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    drv_dma(1'b0, 1'b0, 32'h0, 32'h0);
    step();
`else
    step();
    chk("fp_g1_addr", mem_addr, 32'h80);
    step();
    chk("fp_g1_cpu_ack", cpu_ack, 32'd1);
    chk("fp_g1_dma_ack", dma_ack, 32'd0);
    drv_cpu(1'b1, 1'b1, 32'h88, 32'h33);
    step();
    chk("fp_c3_dma_ack", dma_ack, 32'd0);
    step();
    chk("fp_g2_addr", mem_addr, 32'h88);
    step();
    chk("fp_g2_cpu_ack", cpu_ack, 32'd1);
    chk("fp_g2_dma_ack", dma_ack, 32'd0);
    drv_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    step(); step();
    chk("fp_g3_addr", mem_addr, 32'h84);
    chk("fp_g3_wdata", mem_wdata, 32'h22);
    step();
    chk("fp_g3_dma_ack", dma_ack, 32'd1);
    chk("fp_g3_cpu_ack", cpu_ack, 32'd0);
    drv_dma(1'b0, 1'b0, 32'h0, 32'h0);
    step();
`endif

    // reset while a CPU read waits for data
    drv_cpu(1'b1, 1'b0, 32'h10, 32'h0);
    step();
    chk("ra_en_c1", mem_en, 32'd1);
    step();
    reset = 1'b1; #1;
    chk("ra_mem_en", mem_en, 32'd0);
    chk("ra_mem_addr", mem_addr, 32'd0);
    chk("ra_cpu_ack", cpu_ack, 32'd0);
    chk("ra_cpu_rdata", cpu_rdata, 32'd0);
    chk("ra_dma_rdata", dma_rdata, 32'd0);
    drv_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    reset = 1'b0;
    step(); step();
    chk("ra_no_ack_a", cpu_ack, 32'd0);
    step();
    chk("ra_no_ack_b", cpu_ack, 32'd0);
    chk("ra_no_en", mem_en, 32'd0);
    drv_cpu(1'b1, 1'b1, 32'h30, 32'hCAFE_0030);
    step();
    chk("ra_new_en", mem_en, 32'd1);
    chk("ra_new_addr", mem_addr, 32'h30);
    step();
    chk("ra_new_ack", cpu_ack, 32'd1);
    drv_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
